// File: rtl/prompt_sequencer.sv
// Round sequencer for the prompt sprite: gap, show, score a response or
// time out, with all sprite changes aligned to the start of a frame.
module prompt_sequencer #(
  parameter int GAP_FRAMES  = 30,
  parameter int RESP_FRAMES = 60,
  parameter int NUM_ROUNDS  = 10,
  parameter int FRAME_W     = 8,
  parameter int SCORE_W     = 4,
  parameter int ROUND_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         hCount,
  input  logic [9:0]         vCount,
  input  logic               start,
  input  logic               btn_valid,
  input  logic [1:0]         btn_code,
  output logic               sprite_en,
  output logic [1:0]         sprite_sel,
  output logic               busy,
  output logic               done,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [ROUND_W-1:0] round
);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SHOW,
    DONE
  } state_t;

  state_t               state;
  logic [FRAME_W-1:0]   fcnt;
  logic                 responded;
  logic [7:0]           lfsr;
  logic                 hv_prev;

  logic                 at_origin;
  logic                 frame_tick;
  logic                 resp;
  logic                 code_ok;
  logic                 gap_last;
  logic                 resp_last;
  logic [ROUND_W-1:0]   round_next;
  logic                 round_last;
  logic [7:0]           lfsr_next;

  // hCount may sit at 0 for several clks; only the first one ticks
  assign at_origin  = (hCount == 10'd0) && (vCount == 10'd0);
  assign frame_tick = at_origin && !hv_prev;

  assign resp       = btn_valid && !responded;
  assign code_ok    = btn_code == sprite_sel;
  assign gap_last   = fcnt == FRAME_W'(GAP_FRAMES - 1);
  assign resp_last  = fcnt == FRAME_W'(RESP_FRAMES - 1);
  assign round_next = round + 1'b1;
  assign round_last = round_next == ROUND_W'(NUM_ROUNDS);

  // Galois form of x^8+x^6+x^5+x^4+1
  assign lfsr_next  = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fcnt       <= '0;
      responded  <= 1'b0;
      lfsr       <= 8'hA5;
      hv_prev    <= 1'b0;
      sprite_en  <= 1'b0;
      sprite_sel <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      round      <= '0;
    end else begin
      lfsr       <= lfsr_next;
      hv_prev    <= at_origin;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= GAP;
            busy  <= 1'b1;
            done  <= 1'b0;
            score <= '0;
            round <= '0;
            fcnt  <= '0;
          end
        end
        GAP: begin
          if (frame_tick) begin
            if (gap_last) begin
              state      <= SHOW;
              sprite_en  <= 1'b1;
              sprite_sel <= lfsr[1:0];
              fcnt       <= '0;
              responded  <= 1'b0;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        SHOW: begin
          if (resp) begin
            responded <= 1'b1;
            if (code_ok) begin
              hit_pulse <= 1'b1;
              if (score != '1) score <= score + 1'b1;
            end else begin
              miss_pulse <= 1'b1;
            end
          end
          // a response on the timeout tick replaces the timeout miss
          if (frame_tick) begin
            if (responded || resp_last) begin
              if (!responded && !resp) miss_pulse <= 1'b1;
              round     <= round_next;
              sprite_en <= 1'b0;
              fcnt      <= '0;
              if (round_last) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prompt_sequencer.sv
// Bench for prompt_sequencer: directed vector table, reset corner case,
// then random frames/buttons against a round-level reference model.
module tb_prompt_sequencer;

  localparam int GAP  = 2;
  localparam int RESP = 3;
  localparam int NR   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hCount = 10'd5;
  logic [9:0] vCount = 10'd5;
  logic       start = 1'b0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_code = 2'd0;
  logic       sprite_en;
  logic [1:0] sprite_sel;
  logic       busy;
  logic       done;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [3:0] score;
  logic [3:0] round;

  int checks = 0;
  int failures = 0;

  prompt_sequencer #(
    .GAP_FRAMES(GAP), .RESP_FRAMES(RESP), .NUM_ROUNDS(NR),
    .FRAME_W(8), .SCORE_W(4), .ROUND_W(4)
  ) dut (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .start(start), .btn_valid(btn_valid), .btn_code(btn_code),
    .sprite_en(sprite_en), .sprite_sel(sprite_sel), .busy(busy),
    .done(done), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .round(round)
  );

  always #5 clk = ~clk;

  // reference model: game phase, frame count, response flag, tallies
  int  m_phase;
  int  m_frames;
  bit  m_resp;
  int  m_score;
  int  m_round;
  int  m_sel;
  int  m_steps;
  bit  m_prev;
  bit  e_hit, e_miss;

  function automatic int lfsr_n(input int n);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < n; i++)
      l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    return int'(l[1:0]);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_frames = 0; m_resp = 0;
    m_score = 0; m_round = 0; m_sel = 0;
    m_steps = 0; m_prev = 0; e_hit = 0; e_miss = 0;
  endtask

  task automatic model_update(input bit z, input bit st, input bit bv,
                              input logic [1:0] code);
    bit tick, fresh, was;
    tick = z && !m_prev;
    m_prev = z;
    e_hit = 0;
    e_miss = 0;
    case (m_phase)
      0, 3: if (st) begin
        m_phase = 1; m_frames = 0; m_score = 0; m_round = 0;
      end
      1: if (tick) begin
        m_frames++;
        if (m_frames == GAP) begin
          m_phase = 2; m_sel = lfsr_n(m_steps);
          m_frames = 0; m_resp = 0;
        end
      end
      2: begin
        fresh = bv && !m_resp;
        was = m_resp;
        if (fresh) begin
          m_resp = 1;
          if (int'(code) == m_sel) begin
            e_hit = 1;
            if (m_score < 15) m_score++;
          end else e_miss = 1;
        end
        if (tick) begin
          m_frames++;
          if (was || m_frames == RESP) begin
            if (!fresh && !was) e_miss = 1;
            m_round++;
            m_frames = 0;
            m_phase = (m_round == NR) ? 3 : 1;
          end
        end
      end
      default: ;
    endcase
    m_steps++;
  endtask

  task automatic check_model(input string tag);
    logic [4:0] exp_f, got_f;
    exp_f = {m_phase == 2, m_phase == 1 || m_phase == 2, m_phase == 3,
             e_hit, e_miss};
    got_f = {sprite_en, busy, done, hit_pulse, miss_pulse};
    checks++;
    if (got_f !== exp_f || score !== 4'(m_score) || round !== 4'(m_round)
        || (m_phase == 2 && sprite_sel !== 2'(m_sel))) begin
      failures++;
      $display("FAIL %s t=%0t flags(en,busy,done,hit,miss) got=%b want=%b score got=%0d want=%0d round got=%0d want=%0d sel got=%0d want=%0d",
               tag, $time, got_f, exp_f, score, m_score, round, m_round,
               sprite_sel, m_sel);
    end
  endtask

  task automatic step(input bit z, input bit st, input bit bv,
                      input logic [1:0] code, input string tag);
    @(negedge clk);
    hCount = z ? 10'd0 : 10'($urandom_range(1, 799));
    vCount = z ? 10'd0 : 10'($urandom_range(0, 524));
    start = st;
    btn_valid = bv;
    btn_code = code;
    model_update(z, st, bv, code);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    hCount = 10'd7; vCount = 10'd7;
    start = 0; btn_valid = 0;
    rst = 1;
    #1;
    model_reset();
    checks++;
    if ({sprite_en, busy, done, hit_pulse, miss_pulse} !== 5'b0 ||
        score !== 4'd0 || round !== 4'd0) begin
      failures++;
      $display("FAIL async_reset en=%b busy=%b done=%b score=%0d round=%0d want all zero",
               sprite_en, busy, done, score, round);
    end
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    bit z, st, bv, ok;
    bit en, busy, done, hit, miss;
    int score, round;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit z, bit st, bit bv, bit ok, bit en,
                              bit bz, bit dn, bit h, bit m, int s, int r);
    vec_t v;
    v.z = z; v.st = st; v.bv = bv; v.ok = ok;
    v.en = en; v.busy = bz; v.done = dn; v.hit = h; v.miss = m;
    v.score = s; v.round = r;
    return v;
  endfunction

  initial begin
    logic [1:0] c;
    //          z st bv ok  en bz dn h  m  s  r
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 2));

    model_reset();
    #12;
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      c = 2'(m_sel ^ (tbl[i].ok ? 0 : 1));
      step(tbl[i].z, tbl[i].st, tbl[i].bv, c, "model_dir");
      checks++;
      if ({sprite_en, busy, done, hit_pulse, miss_pulse} !==
          {tbl[i].en, tbl[i].busy, tbl[i].done, tbl[i].hit, tbl[i].miss} ||
          score !== 4'(tbl[i].score) || round !== 4'(tbl[i].round)) begin
        failures++;
        $display("FAIL vec%0d en,busy,done,hit,miss got=%b%b%b%b%b want=%b%b%b%b%b score got=%0d want=%0d round got=%0d want=%0d",
                 i, sprite_en, busy, done, hit_pulse, miss_pulse,
                 tbl[i].en, tbl[i].busy, tbl[i].done, tbl[i].hit, tbl[i].miss,
                 score, tbl[i].score, round, tbl[i].round);
      end
    end

    // new game, score a hit, then reset while the prompt is up
    step(0, 1, 0, 2'd0, "rst_seq");
    step(1, 0, 0, 2'd0, "rst_seq");
    step(0, 0, 0, 2'd0, "rst_seq");
    step(1, 0, 0, 2'd0, "rst_seq");
    step(0, 0, 1, 2'(m_sel), "rst_seq");
    checks++;
    if (sprite_en !== 1'b1 || score !== 4'd1) begin
      failures++;
      $display("FAIL pre_reset_show en=%b score=%0d want en=1 score=1",
               sprite_en, score);
    end
    do_reset();

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), "rand");
    end

    start = 0;
    btn_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
